// File: rtl/ifu_multi_if.sv
// Shared exception encoding and the MMU/ICache fetch port bundle for ifu_multi.
package ifu_multi_pkg;
  typedef enum logic [1:0] {
    EXC_ADEF = 2'd0,
    EXC_TLBR = 2'd1,
    EXC_PIF  = 2'd2,
    EXC_PPI  = 2'd3
  } exception_t;
endpackage

interface ifu_multi_if #(
  parameter int FETCH_WIDTH = 4
) ();
  localparam int SW = $clog2(FETCH_WIDTH + 1);

  logic                     mmu_i_valid;
  logic [31:0]              mmu_i_addr;
  logic [SW-1:0]            mmu_i_size;
  logic                     mmu_i_addr_ok;
  logic                     mmu_i_data_ok;
  logic [32*FETCH_WIDTH-1:0] mmu_i_rdata;
  logic                     mmu_i_tlbr;
  logic                     mmu_i_pif;
  logic                     mmu_i_ppi;

  modport master (
    output mmu_i_valid, mmu_i_addr, mmu_i_size,
    input  mmu_i_addr_ok, mmu_i_data_ok, mmu_i_rdata, mmu_i_tlbr, mmu_i_pif, mmu_i_ppi
  );

  modport slave (
    input  mmu_i_valid, mmu_i_addr, mmu_i_size,
    output mmu_i_addr_ok, mmu_i_data_ok, mmu_i_rdata, mmu_i_tlbr, mmu_i_pif, mmu_i_ppi
  );
endinterface

// File: rtl/ifu_multi.sv
// Multi-outstanding instruction fetch unit: aligned group fetch, stale-response drop on redirect,
// in-order delivery of instructions or a fault pseudo-instruction. IFU_PERF_EN adds perf counters.
module ifu_multi
  import ifu_multi_pkg::*;
#(
  parameter int          FETCH_WIDTH     = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                ibuf_ready,
  output logic [$clog2(FETCH_WIDTH+1)-1:0]    ibuf_input_size,
  output logic [31:0]                         fetch_pc,
  output logic [32*FETCH_WIDTH-1:0]           fetch_inst,
  output logic                                have_exception,
  output exception_t                          exception_type,
  input  logic                                branch_mistaken,
  input  logic [31:0]                         correct_target,
  input  logic                                raise_exception,
  input  logic [31:0]                         exception_target,
  ifu_multi_if.master                         mmu
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]                         perf_inst_cnt,
  output logic [31:0]                         perf_drop_cnt
`endif
);
  localparam int          SW        = $clog2(FETCH_WIDTH + 1);
  localparam int          PW        = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int          CW        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] GRP_BYTES = 32'(4 * FETCH_WIDTH);
  localparam logic [31:0] GRP_MASK  = GRP_BYTES - 32'd1;

  logic [31:0]                pc_q, pc_d;
  logic [31:0]                ent_pc_q   [MAX_OUTSTANDING];
  logic [SW-1:0]              ent_size_q [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] ent_stale_q;
  logic [PW-1:0]              head_q, tail_q;
  logic [CW-1:0]              count_q, count_d;

  logic          redirect, fault_now, push, pop, deliver, exc_out;
  exception_t    fault_type;
  logic [31:0]   words_left, next_pc, head_pc, head_off;
  logic [SW-1:0] req_size, head_size;
  logic          head_stale;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign redirect   = raise_exception | branch_mistaken;
  assign words_left = (GRP_BYTES - (pc_q & GRP_MASK)) >> 2;
  assign req_size   = words_left[SW-1:0];
  assign next_pc    = (pc_q & ~GRP_MASK) + GRP_BYTES;

  always_comb begin
    fault_now  = 1'b1;
    fault_type = EXC_ADEF;
    if (pc_q[1:0] != 2'b00) fault_type = EXC_ADEF;
    else if (mmu.mmu_i_tlbr) fault_type = EXC_TLBR;
    else if (mmu.mmu_i_pif)  fault_type = EXC_PIF;
    else if (mmu.mmu_i_ppi)  fault_type = EXC_PPI;
    else                     fault_now  = 1'b0;
  end

  // A response in this cycle frees a slot, so a full FIFO may still issue.
  assign mmu.mmu_i_valid = !reset && !fault_now && !redirect && ibuf_ready &&
                           ((count_q < CW'(MAX_OUTSTANDING)) || mmu.mmu_i_data_ok);
  assign mmu.mmu_i_addr  = pc_q;
  assign mmu.mmu_i_size  = req_size;

  assign push       = mmu.mmu_i_valid && mmu.mmu_i_addr_ok;
  assign pop        = !reset && mmu.mmu_i_data_ok && (count_q != '0);
  assign head_pc    = ent_pc_q[head_q];
  assign head_size  = ent_size_q[head_q];
  assign head_stale = ent_stale_q[head_q];
  assign head_off   = (head_pc & GRP_MASK) >> 2;
  assign deliver    = pop && !head_stale && !redirect;
  assign exc_out    = !reset && fault_now && !redirect && (count_q == '0) && ibuf_ready;

  always_comb begin
    int unsigned hidx;
    int unsigned j;
    ibuf_input_size = '0;
    fetch_pc        = pc_q;
    have_exception  = 1'b0;
    exception_type  = fault_type;
    hidx            = head_off;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      j = (hidx + i) % FETCH_WIDTH;
      fetch_inst[32*i +: 32] = mmu.mmu_i_rdata[32*j +: 32];
    end
    if (deliver) begin
      ibuf_input_size = head_size;
      fetch_pc        = head_pc;
    end else if (exc_out) begin
      ibuf_input_size = SW'(1);
      have_exception  = 1'b1;
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect) pc_d = raise_exception ? exception_target : correct_target;
    else if (push) pc_d = next_pc;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ent_stale_q <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      if (push) begin
        ent_pc_q[tail_q]   <= pc_q;
        ent_size_q[tail_q] <= req_size;
        tail_q             <= ptr_inc(tail_q);
      end
      if (pop) head_q <= ptr_inc(head_q);
      // Redirect never coincides with a push, so staling every slot covers all survivors.
      if (redirect) ent_stale_q <= '1;
      else if (push) ent_stale_q[tail_q] <= 1'b0;
    end
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_inst_cnt <= '0;
      perf_drop_cnt <= '0;
    end else begin
      if (deliver) perf_inst_cnt <= perf_inst_cnt + 32'(head_size);
      if (pop && (head_stale || redirect)) perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_multi.sv
// Directed bench for ifu_multi with a latency-configurable MMU model and a delivery scoreboard.
module tb_ifu_multi;
  import ifu_multi_pkg::*;

  localparam int FW = 4;
  localparam int MO = 2;

  logic         clk = 1'b0;
  logic         reset, ibuf_ready, branch_mistaken, raise_exception;
  logic [31:0]  correct_target, exception_target;
  logic [2:0]   ibuf_input_size;
  logic [31:0]  fetch_pc;
  logic [127:0] fetch_inst;
  logic         have_exception;
  exception_t   exception_type;
`ifdef IFU_PERF_EN
  logic [31:0]  perf_inst_cnt, perf_drop_cnt;
`endif

  ifu_multi_if #(.FETCH_WIDTH(FW)) mmu ();

  ifu_multi #(.FETCH_WIDTH(FW), .MAX_OUTSTANDING(MO), .RESET_PC(32'h1c000000)) dut (
    .clk(clk), .reset(reset), .ibuf_ready(ibuf_ready), .ibuf_input_size(ibuf_input_size),
    .fetch_pc(fetch_pc), .fetch_inst(fetch_inst), .have_exception(have_exception),
    .exception_type(exception_type), .branch_mistaken(branch_mistaken),
    .correct_target(correct_target), .raise_exception(raise_exception),
    .exception_target(exception_target), .mmu(mmu)
`ifdef IFU_PERF_EN
    , .perf_inst_cnt(perf_inst_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  size;
    logic [31:0] pc;
    logic        exc;
    exception_t  etype;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t mq[$];
  req_t nr;
  int   cyc = 0;
  int   lat = 1;
  logic hold = 1'b0;
  logic s_rst, s_acc, s_pop;
  logic [31:0] s_addr;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A50000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] s, input logic [31:0] p, input logic e, input exception_t t);
    exp_t x;
    x.size = s; x.pc = p; x.exc = e; x.etype = t;
    sb.push_back(x);
  endtask

  task automatic chk_req(input string nm, input logic v, input logic [31:0] a, input logic [2:0] s);
    check32({nm, "_valid"}, 32'(mmu.mmu_i_valid), 32'(v));
    if (v) begin
      check32({nm, "_addr"}, mmu.mmu_i_addr, a);
      check32({nm, "_size"}, 32'(mmu.mmu_i_size), 32'(s));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // MMU model: samples at negedge, updates at posedge, drives response just after the edge.
  initial begin
    mmu.mmu_i_data_ok = 1'b0;
    mmu.mmu_i_rdata   = '0;
    forever begin
      @(negedge clk);
      s_rst  = reset;
      s_acc  = mmu.mmu_i_valid && mmu.mmu_i_addr_ok;
      s_pop  = mmu.mmu_i_data_ok;
      s_addr = mmu.mmu_i_addr;
      @(posedge clk);
      cyc++;
      if (s_rst) mq.delete();
      else begin
        if (s_pop && mq.size() > 0) void'(mq.pop_front());
        if (s_acc) begin
          nr.addr = s_addr;
          nr.due  = cyc + lat - 1;
          mq.push_back(nr);
        end
      end
      #2;
      if (!reset && !hold && mq.size() > 0 && mq[0].due <= cyc) begin
        mmu.mmu_i_data_ok = 1'b1;
        for (int j = 0; j < FW; j++)
          mmu.mmu_i_rdata[32*j +: 32] = word_of((mq[0].addr & ~32'hF) + 32'(4*j));
      end else begin
        mmu.mmu_i_data_ok = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0 && ibuf_input_size != 3'd0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_delivery: got size %0d pc %h exc %0d, expected no delivery",
                 ibuf_input_size, fetch_pc, have_exception);
      end else begin
        mon_e = sb.pop_front();
        check32("dlv_size", 32'(ibuf_input_size), 32'(mon_e.size));
        check32("dlv_pc", fetch_pc, mon_e.pc);
        check32("dlv_exc", 32'(have_exception), 32'(mon_e.exc));
        if (mon_e.exc) check32("dlv_etype", 32'(exception_type), 32'(mon_e.etype));
        else
          for (int k = 0; k < 32'(mon_e.size); k++)
            check32("dlv_lane", fetch_inst[32*k +: 32], word_of(mon_e.pc + 32'(4*k)));
      end
    end
  end

  initial begin
    reset = 1'b1; ibuf_ready = 1'b0; branch_mistaken = 1'b0; raise_exception = 1'b0;
    correct_target = '0; exception_target = '0;
    mmu.mmu_i_addr_ok = 1'b1; mmu.mmu_i_tlbr = 1'b0; mmu.mmu_i_pif = 1'b0; mmu.mmu_i_ppi = 1'b0;

    repeat (3) step();
    at_neg();
    check32("rst_valid", 32'(mmu.mmu_i_valid), 32'd0);
    check32("rst_size", 32'(ibuf_input_size), 32'd0);
    check32("rst_exc", 32'(have_exception), 32'd0);

    // Reset release, back-to-back fetch of two groups
    push_exp(3'd4, 32'h1c000000, 1'b0, EXC_ADEF);
    push_exp(3'd4, 32'h1c000010, 1'b0, EXC_ADEF);
    step(); reset = 1'b0; ibuf_ready = 1'b1;
    at_neg(); chk_req("p1_req0", 1'b1, 32'h1c000000, 3'd4);
    step(); at_neg(); chk_req("p1_req1", 1'b1, 32'h1c000010, 3'd4);
    step(); ibuf_ready = 1'b0;
    at_neg(); chk_req("p1_idle", 1'b0, 32'h0, 3'd0);
    repeat (2) step();

    // Misaligned-in-group redirect
    push_exp(3'd2, 32'h1c000008, 1'b0, EXC_ADEF);
    push_exp(3'd4, 32'h1c000010, 1'b0, EXC_ADEF);
    step(); branch_mistaken = 1'b1; correct_target = 32'h1c000008; ibuf_ready = 1'b1;
    at_neg(); chk_req("p2_redirect", 1'b0, 32'h0, 3'd0);
    step(); branch_mistaken = 1'b0;
    at_neg(); chk_req("p2_req0", 1'b1, 32'h1c000008, 3'd2);
    step(); at_neg(); chk_req("p2_req1", 1'b1, 32'h1c000010, 3'd4);
    step(); ibuf_ready = 1'b0;
    repeat (2) step();

    // Two in flight, flushed by branch_mistaken
    step(); hold = 1'b1; ibuf_ready = 1'b1;
    at_neg(); chk_req("p3_req0", 1'b1, 32'h1c000020, 3'd4);
    step(); at_neg(); chk_req("p3_req1", 1'b1, 32'h1c000030, 3'd4);
    step(); at_neg(); chk_req("p3_full", 1'b0, 32'h0, 3'd0);
    step(); ibuf_ready = 1'b0; branch_mistaken = 1'b1; correct_target = 32'h1c000100;
    at_neg(); chk_req("p3_redirect", 1'b0, 32'h0, 3'd0);
    step(); branch_mistaken = 1'b0; hold = 1'b0;
    at_neg();
    check32("p3_stale0_resp", 32'(mmu.mmu_i_data_ok), 32'd1);
    check32("p3_stale0_size", 32'(ibuf_input_size), 32'd0);
    step(); at_neg();
    check32("p3_stale1_resp", 32'(mmu.mmu_i_data_ok), 32'd1);
    check32("p3_stale1_size", 32'(ibuf_input_size), 32'd0);
    push_exp(3'd4, 32'h1c000100, 1'b0, EXC_ADEF);
    step(); ibuf_ready = 1'b1;
    at_neg(); chk_req("p3_req_new", 1'b1, 32'h1c000100, 3'd4);
    step(); ibuf_ready = 1'b0;
    repeat (2) step();
`ifdef IFU_PERF_EN
    check32("p3_perf_drop", perf_drop_cnt, 32'd2);
    check32("p3_perf_inst", perf_inst_cnt, 32'd18);
`endif

    // Address error at a misaligned target
    step(); branch_mistaken = 1'b1; correct_target = 32'h1c000102;
    push_exp(3'd1, 32'h1c000102, 1'b1, EXC_ADEF);
    push_exp(3'd1, 32'h1c000102, 1'b1, EXC_ADEF);
    step(); branch_mistaken = 1'b0; ibuf_ready = 1'b1;
    at_neg(); chk_req("p4_adef", 1'b0, 32'h0, 3'd0);
    step(); at_neg();
    step(); ibuf_ready = 1'b0; raise_exception = 1'b1; exception_target = 32'h1c000030;
    step(); raise_exception = 1'b0;

    // Translation fault with one entry still in flight
    push_exp(3'd4, 32'h1c000030, 1'b0, EXC_ADEF);
    push_exp(3'd1, 32'h1c000040, 1'b1, EXC_TLBR);
    step(); ibuf_ready = 1'b1;
    at_neg(); chk_req("p5_req", 1'b1, 32'h1c000030, 3'd4);
    step(); mmu.mmu_i_tlbr = 1'b1; mmu.mmu_i_ppi = 1'b1;
    at_neg(); chk_req("p5_fault", 1'b0, 32'h0, 3'd0);
    step(); at_neg();
    step(); ibuf_ready = 1'b0; mmu.mmu_i_tlbr = 1'b0; mmu.mmu_i_ppi = 1'b0;
    branch_mistaken = 1'b1; correct_target = 32'h1c000200; lat = 5;
    step(); branch_mistaken = 1'b0;

    // Long latency: outstanding limit, resume on data_ok, combined redirect
    push_exp(3'd4, 32'h1c000200, 1'b0, EXC_ADEF);
    push_exp(3'd4, 32'h1c000300, 1'b0, EXC_ADEF);
    step(); ibuf_ready = 1'b1;
    at_neg(); chk_req("p6_req0", 1'b1, 32'h1c000200, 3'd4);
    step(); at_neg(); chk_req("p6_req1", 1'b1, 32'h1c000210, 3'd4);
    for (int k = 0; k < 3; k++) begin
      step(); at_neg(); chk_req("p6_wait", 1'b0, 32'h0, 3'd0);
    end
    step(); at_neg(); chk_req("p6_resume", 1'b1, 32'h1c000220, 3'd4);
    step(); raise_exception = 1'b1; branch_mistaken = 1'b1;
    exception_target = 32'h1c000300; correct_target = 32'h1c000400;
    at_neg(); chk_req("p6_redirect", 1'b0, 32'h0, 3'd0);
    step(); raise_exception = 1'b0; branch_mistaken = 1'b0;
    at_neg(); chk_req("p6_exc_target", 1'b1, 32'h1c000300, 3'd4);
    step(); ibuf_ready = 1'b0; lat = 1;
    repeat (8) step();
`ifdef IFU_PERF_EN
    check32("p6_perf_drop", perf_drop_cnt, 32'd4);
    check32("p6_perf_inst", perf_inst_cnt, 32'd30);
`endif

    // Reset with a request in flight
    push_exp(3'd4, 32'h1c000000, 1'b0, EXC_ADEF);
    step(); ibuf_ready = 1'b1;
    at_neg(); chk_req("p7_req", 1'b1, 32'h1c000310, 3'd4);
    step(); reset = 1'b1;
    at_neg(); chk_req("p7_rst", 1'b0, 32'h0, 3'd0);
    check32("p7_rst_size", 32'(ibuf_input_size), 32'd0);
    step(); reset = 1'b0;
    at_neg(); chk_req("p7_req_after_rst", 1'b1, 32'h1c000000, 3'd4);
    step(); ibuf_ready = 1'b0;
    repeat (3) step();
`ifdef IFU_PERF_EN
    check32("p7_perf_inst", perf_inst_cnt, 32'd4);
`endif

    check32("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_multi.md
Name: ifu_multi

Overview:
- Parametrised next-generation instruction fetch unit.
- Issues aligned fetch groups of up to FETCH_WIDTH instructions to the MMU/ICache port and keeps up to MAX_OUTSTANDING requests in flight.
- Discards stale responses after a redirect.
- Delivers instructions, or a single exception pseudo-instruction, to the instruction buffer in program order.

Parameters:
- FETCH_WIDTH, 4: instructions per aligned fetch group; power of two, 1..8.
- MAX_OUTSTANDING, 2: maximum accepted requests awaiting data; 1..4.
- RESET_PC, 32'h1c000000: fetch address after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ibuf_ready  in  1  ibuf can accept one full fetch group this cycle
- ibuf_input_size  out  $clog2(FETCH_WIDTH+1)  number of valid lanes delivered this cycle (0 = none)
- fetch_pc  out  32  PC of lane 0; lane i PC = fetch_pc + 4*i
- fetch_inst  out  32*FETCH_WIDTH  lane i at bits [32*i+31:32*i]
- have_exception  out  1  delivered lane 0 is an exception pseudo-instruction
- exception_type  out  exception_t  ADEF/TLBR/PIF/PPI
- branch_mistaken  in  1  redirect to correct_target
- correct_target  in  32  branch redirect PC
- raise_exception  in  1  redirect to exception_target; has priority over branch_mistaken
- exception_target  in  32  exception entry PC
- mmu_i_valid  out  1  request valid
- mmu_i_addr  out  32  request PC
- mmu_i_size  out  $clog2(FETCH_WIDTH+1)  words requested
- mmu_i_addr_ok  in  1  request accepted
- mmu_i_data_ok  in  1  in-order response valid
- mmu_i_rdata  in  32*FETCH_WIDTH  whole aligned group, word j at bits [32*j+31:32*j]
- mmu_i_tlbr, mmu_i_pif, mmu_i_ppi  in  1 each  translation faults for the current mmu_i_addr, valid combinationally in the same cycle

Behaviour:
- State:
  - pc: next fetch PC.
  - In-flight FIFO of depth MAX_OUTSTANDING; each entry holds {pc, size, stale}.
  - occupancy count.
- Reset: pc=RESET_PC, FIFO empty, all stale bits 0. mmu_i_valid=0, ibuf_input_size=0, have_exception=0.
- Let idx = pc[$clog2(FETCH_WIDTH)+1:2]. Then:
  - mmu_i_size = FETCH_WIDTH - idx.
  - next_pc = {pc[31:$clog2(FETCH_WIDTH)+2] + 1, zeros}.
  - When FETCH_WIDTH=1: size=1 and next_pc = pc+4.
- Fault detection, priority order:
  - pc[1:0]!=0 gives ADEF.
  - Otherwise mmu_i_tlbr gives TLBR, then pif gives PIF, then ppi gives PPI.
  - The result is fault_now.
- Issue: mmu_i_valid = !reset && !fault_now && !redirect && ibuf_ready && (occupancy<MAX_OUTSTANDING || mmu_i_data_ok).
  - mmu_i_addr = pc.
  - On valid&&addr_ok: push {pc, size, 0} and set pc <= next_pc.
  - Push and pop in the same cycle are allowed.
- Response: mmu_i_data_ok pops the head entry. The MMU never asserts data_ok with an empty FIFO.
  - If head.stale or redirect this cycle: ibuf_input_size=0.
  - Otherwise: ibuf_input_size=head.size, fetch_pc=head.pc, and lane i = rdata word (head idx + i).
  - Lanes >= size are don't-care.
- Redirect (raise_exception || branch_mistaken):
  - pc <= exception_target if raise_exception, else correct_target.
  - Every entry remaining in the FIFO after this cycle's pop is marked stale.
  - No new request is issued that cycle.
  - Stale entries still pop on their data_ok and deliver nothing.
- Exception delivery:
  - While fault_now and no redirect, nothing is issued.
  - Once the FIFO is empty and ibuf_ready=1: have_exception=1, exception_type set, ibuf_input_size=1, fetch_pc=pc. Lane 0 data is don't-care.
  - This repeats every ready cycle until a redirect clears it. The ibuf/backend guarantees a redirect follows.
  - have_exception is never asserted while any entry, stale or not, is in flight.
- A response and an exception never coincide in the same cycle: exception delivery requires an empty FIFO.
- Reset mid-operation: the FIFO is flushed immediately. The MMU is reset by the same signal, so no late data_ok arrives.
- Throughput: a single group per cycle sustained when addr_ok and data_ok are back-to-back and MAX_OUTSTANDING >= 2.

Optional Feature:
- Macro IFU_PERF_EN.
- Defined: adds outputs perf_inst_cnt[31:0] and perf_drop_cnt[31:0].
  - perf_inst_cnt adds ibuf_input_size for every non-exception delivery.
  - perf_drop_cnt increments for each response discarded because it was stale or arrived in a redirect cycle.
  - Both counters clear on reset and wrap at 2^32.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset release, ready=1, addr_ok=1, 1-cycle data -> requests at 0x1c000000 (size 4) then 0x1c000010. First delivery: size=4, fetch_pc=0x1c000000, lanes = rdata words 0..3.
- Redirect to 0x1c000008 -> request at 0x1c000008 with size 2, then 0x1c000010. Delivery: size=2, lane0=word2, lane1=word3.
- Two requests in flight, data_ok withheld, branch_mistaken to 0x1c000100 -> both responses discarded (size 0, perf_drop_cnt=2 with IFU_PERF_EN). Next delivery has fetch_pc=0x1c000100.
- correct_target=0x1c000102 -> no request issued. Once the FIFO drains: have_exception=1, ADEF, size=1, fetch_pc=0x1c000102.
- mmu_i_tlbr and mmu_i_ppi both asserted at pc 0x1c000040 with one entry in flight -> that entry delivers first. Next cycle: have_exception=1, type TLBR.
- MAX_OUTSTANDING=2, data_ok delayed 5 cycles -> exactly 2 accepted requests, then mmu_i_valid=0 until data_ok. Issue resumes in the data_ok cycle; raise_exception and branch_mistaken together take exception_target.
